// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and default constants for the square-root step controller.
// The optional cycle counter in sqrt_ctrl is enabled by defining SQRT_CTRL_CYCLE_CNT_EN.
package sqrt_ctrl_pkg;

    // Default datapath latency and step limits
    localparam int unsigned DEF_LAT        = 3;
    localparam int unsigned DEF_MAX_COARSE = 32;
    localparam int unsigned DEF_MAX_FINE   = 8;

    // Controller states
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCIssue,
        StCWait,
        StFIssue,
        StFWait,
        StDone,
        StErr
    } state_e;

    // Width able to hold every value 0..limit
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sqrt_step_counter.sv
// Saturating step counter: clears on request, counts issued steps and flags when the
// configured limit has been reached. It never wraps.
module sqrt_step_counter
    import sqrt_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_MAX_FINE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int unsigned W = cnt_width(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_limit = (cnt_q == W'(LIMIT));

    // Next count: clear wins, increment stops at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sqrt_ctrl.sv
// Control FSM for an iterative square-root datapath. A computation loads the input, then
// issues coarse (+8) steps until the datapath reports overshoot (N_i), then fine (+1) steps
// until overshoot again. Each step is one issue cycle plus LAT wait cycles; N_i is only
// looked at on the final wait cycle. Running out of steps ends in ERR.
// Optional feature: define SQRT_CTRL_CYCLE_CNT_EN to add the 8-bit cycles_o busy-cycle count.
module sqrt_ctrl
    import sqrt_ctrl_pkg::*;
#(
    parameter int unsigned LAT        = DEF_LAT,
    parameter int unsigned MAX_COARSE = DEF_MAX_COARSE,
    parameter int unsigned MAX_FINE   = DEF_MAX_FINE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       ack_i,
    input  logic       N_i,
    output logic       wr_input_o,
    output logic       en_pipe_o,
    output logic       mux_root_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
`ifdef SQRT_CTRL_CYCLE_CNT_EN
    ,
    output logic [7:0] cycles_o
`endif
);

    localparam int unsigned WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_e state_q;
    state_e state_d;

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              last_wait;

    logic cnt_clr;
    logic coarse_inc;
    logic fine_inc;
    logic coarse_at_limit;
    logic fine_at_limit;

    assign last_wait  = (wait_q == WAIT_W'(LAT - 1));
    assign cnt_clr    = (state_q == StLoad);
    assign coarse_inc = (state_q == StCIssue);
    assign fine_inc   = (state_q == StFIssue);

    sqrt_step_counter #(
        .LIMIT (MAX_COARSE)
    ) u_coarse_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (coarse_inc),
        .at_limit (coarse_at_limit)
    );

    sqrt_step_counter #(
        .LIMIT (MAX_FINE)
    ) u_fine_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (fine_inc),
        .at_limit (fine_at_limit)
    );

    // Next-state logic and wait-cycle counter control
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StCIssue;
            end
            StCIssue: begin
                wait_d  = '0;
                state_d = StCWait;
            end
            StCWait: begin
                if (last_wait) begin
                    if (N_i) begin
                        state_d = StFIssue;
                    end else if (coarse_at_limit) begin
                        state_d = StErr;
                    end else begin
                        state_d = StCIssue;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StFIssue: begin
                wait_d  = '0;
                state_d = StFWait;
            end
            StFWait: begin
                if (last_wait) begin
                    if (N_i) begin
                        state_d = StDone;
                    end else if (fine_at_limit) begin
                        state_d = StErr;
                    end else begin
                        state_d = StFIssue;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StDone, StErr: begin
                // Result is held until acknowledged; ack with start chains straight into LOAD
                if (ack_i) begin
                    state_d = start_i ? StLoad : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs decoded purely from the registered state
    always_comb begin
        wr_input_o = 1'b0;
        en_pipe_o  = 1'b0;
        mux_root_o = 1'b0;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StLoad: begin
                wr_input_o = 1'b1;
                busy_o     = 1'b1;
            end
            StCIssue: begin
                en_pipe_o  = 1'b1;
                mux_root_o = 1'b1;
                busy_o     = 1'b1;
            end
            StCWait: begin
                mux_root_o = 1'b1;
                busy_o     = 1'b1;
            end
            StFIssue: begin
                en_pipe_o = 1'b1;
                busy_o    = 1'b1;
            end
            StFWait: begin
                busy_o = 1'b1;
            end
            StDone: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
            end
            StErr: begin
                done_o = 1'b1;
                err_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef SQRT_CTRL_CYCLE_CNT_EN
    logic [7:0] cyc_q;
    logic [7:0] cyc_d;

    assign cycles_o = cyc_q;

    // LOAD restarts the count at one (itself); later busy cycles add one, saturating
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == StLoad) begin
            cyc_d = 8'd1;
        end else if (busy_o && (cyc_q != 8'hFF)) begin
            cyc_d = cyc_q + 8'd1;
        end
    end

    // Cycle-count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Randomised self-checking bench for sqrt_ctrl. Each transaction is described by the step
// at which the coarse phase overshoots and the step at which the fine phase overshoots
// (0 = never); expected timing and outputs follow from that with plain arithmetic.
module tb_sqrt_ctrl;

    localparam int LAT   = 3;
    localparam int MAX_C = 32;
    localparam int MAX_F = 8;

    logic clk;
    logic rst;
    logic start_i;
    logic ack_i;
    logic N_i;
    logic wr_input_o;
    logic en_pipe_o;
    logic mux_root_o;
    logic ready_o;
    logic busy_o;
    logic done_o;
    logic err_o;
`ifdef SQRT_CTRL_CYCLE_CNT_EN
    logic [7:0] cycles_o;
`endif

    int n_checks;
    int n_fail;

    sqrt_ctrl #(
        .LAT        (LAT),
        .MAX_COARSE (MAX_C),
        .MAX_FINE   (MAX_F)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .ack_i      (ack_i),
        .N_i        (N_i),
        .wr_input_o (wr_input_o),
        .en_pipe_o  (en_pipe_o),
        .mux_root_o (mux_root_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
`ifdef SQRT_CTRL_CYCLE_CNT_EN
        ,
        .cycles_o   (cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every output must be low (idle or in reset)
    task automatic check_quiet(input string tag);
        check_val({tag, "_outs"},
                  {25'd0, wr_input_o, en_pipe_o, mux_root_o, ready_o, busy_o, done_o, err_o}, 0);
`ifdef SQRT_CTRL_CYCLE_CNT_EN
        if (tag != "idle") check_val({tag, "_cycles"}, cycles_o, 0);
`endif
    endtask

    // Overshoot answer the datapath gives for step s (1-based)
    function automatic logic planned_n(input int s, input int cs, input int nc, input int nf);
        if (s <= cs) return logic'(nc != 0 && s == nc);
        return logic'(nf != 0 && (s - cs) == nf);
    endfunction

    // Observe one transaction whose start was sampled on the edge just ahead. nc/nf give the
    // overshooting coarse/fine step (0 = never). b2b chains the next start onto the ack.
    task automatic run_txn(input int nc, input int nf, input bit b2b);
        int cs, fs, k, exp_t;
        bit exp_err;
        int issued, issue_cyc, en_cnt, first_en, wr_cnt, first_wr, mux_cnt, last_mux;
        int done_cyc, busy_gaps;
        cs       = (nc == 0) ? MAX_C : nc;
        fs       = (nc == 0) ? 0 : ((nf == 0) ? MAX_F : nf);
        exp_err  = (nc == 0) || (nf == 0);
        k        = cs + fs;
        exp_t    = 2 + k * (1 + LAT);
        issued   = 0;
        issue_cyc = -100;
        en_cnt   = 0;
        first_en = -1;
        wr_cnt   = 0;
        first_wr = -1;
        mux_cnt  = 0;
        last_mux = -1;
        done_cyc = -1;
        busy_gaps = 0;
        for (int cyc = 1; cyc <= exp_t + 20; cyc++) begin
            @(negedge clk);
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (wr_input_o) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
            end
            if (en_pipe_o) begin
                en_cnt++;
                issued++;
                issue_cyc = cyc;
                if (first_en < 0) first_en = cyc;
            end
            if (mux_root_o) begin
                mux_cnt++;
                last_mux = cyc;
            end
            if (!busy_o) busy_gaps++;
            // Only the last wait cycle carries a meaningful flag; noise elsewhere
            if (cyc - issue_cyc == LAT) N_i = planned_n(issued, cs, nc, nf);
            else N_i = 1'($urandom);
            start_i = 1'($urandom);
            ack_i   = 1'($urandom);
        end
        start_i = 1'b0;
        ack_i   = 1'b0;
        N_i     = 1'b0;
        check_val("done_cycle", done_cyc, exp_t);
        check_val("wr_count", wr_cnt, 1);
        check_val("wr_cycle", first_wr, 1);
        check_val("en_count", en_cnt, k);
        check_val("en_first", first_en, 2);
        check_val("mux_count", mux_cnt, cs * (1 + LAT));
        check_val("mux_last", last_mux, 1 + cs * (1 + LAT));
        check_val("busy_gaps", busy_gaps, 0);
        if (done_cyc > 0) begin
            check_val("err_flag", err_o, exp_err);
            check_val("ready_flag", ready_o, !exp_err);
            check_val("busy_in_done", busy_o, 0);
`ifdef SQRT_CTRL_CYCLE_CNT_EN
            check_val("cycles", cycles_o, exp_t - 1);
`endif
            // Result must be held while unacknowledged, whatever start_i does
            repeat ($urandom_range(0, 3)) begin
                start_i = 1'($urandom);
                @(negedge clk);
                check_val("hold_done", done_o, 1);
                check_val("hold_err", err_o, exp_err);
            end
            ack_i   = 1'b1;
            start_i = b2b;
            if (!b2b) begin
                @(negedge clk);
                ack_i = 1'b0;
                check_quiet("idle");
            end
        end
    endtask

    // Reset while in the wait phase of the second coarse step
    task automatic reset_mid_op();
        int en_seen;
        bit hit;
        en_seen = 0;
        hit     = 1'b0;
        start_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            N_i     = 1'b0;
            if (en_pipe_o) en_seen++;
            else if (en_seen == 2) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("reach_second_wait", hit, 1);
        check_val("busy_before_rst", busy_o, 1);
        #2 rst = 1'b1;
        #1 check_quiet("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_rst");
    endtask

    initial begin
        bit prev_b2b;
        bit b2b;
        int nc;
        int nf;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start_i  = 1'b0;
        ack_i    = 1'b0;
        N_i      = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // First start right after reset release; shortest normal run
        start_i = 1'b1;
        run_txn(1, 1, 1'b0);
        // Three coarse, two fine, chained straight into a coarse-exhaustion error
        start_i = 1'b1;
        run_txn(3, 2, 1'b1);
        run_txn(0, 1, 1'b0);
        // Fine exhaustion error
        start_i = 1'b1;
        run_txn(4, 0, 1'b0);

        reset_mid_op();
        start_i = 1'b1;
        run_txn(2, 5, 1'b0);

        prev_b2b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nc = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MAX_C));
            nf = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAX_F));
            b2b = (i != 11) && ($urandom_range(0, 1) == 1);
            if (!prev_b2b) start_i = 1'b1;
            run_txn(nc, nf, b2b);
            prev_b2b = b2b;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_ctrl.md
SQRT_CTRL -- requirements
Module: sqrt_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from an issued step to its valid N flag.
REQ-002 SHALL have parameter MAX_COARSE, default 32: coarse-step limit.
REQ-003 SHALL have parameter MAX_FINE, default 8: fine-step limit.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports as in REQ-005 and REQ-006.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start_i  input  1  request a new root computation; sampled in IDLE or DONE/ERR.
REQ-008 ack_i  input  1  consumer acknowledges result; releases DONE/ERR.
REQ-009 N_i  input  1  datapath flag: candidate square exceeds input.
REQ-010 wr_input_o  output  1  datapath input-register write strobe.
REQ-011 en_pipe_o  output  1  datapath pipeline-advance strobe, one cycle per step.
REQ-012 mux_root_o  output  1  step select: 1 = coarse (+8), 0 = fine (+1).
REQ-013 ready_o  output  1  datapath ready marker, high in DONE.
REQ-014 busy_o  output  1  high in every state except IDLE, DONE and ERR.
REQ-015 done_o  output  1  high in DONE and ERR.
REQ-016 err_o  output  1  high in ERR only.

Function
REQ-017 SHALL implement states IDLE, LOAD, C_ISSUE, C_WAIT, F_ISSUE, F_WAIT, DONE and ERR.
REQ-018 IDLE: start_i=1 -> LOAD next cycle; otherwise stay.
REQ-019 LOAD: one cycle, wr_input_o=1 -> C_ISSUE.
REQ-020 C_ISSUE: one cycle, en_pipe_o=1, mux_root_o=1, coarse count +1 -> C_WAIT.
REQ-021 C_WAIT: exactly LAT cycles, en_pipe_o=0, mux_root_o=1; N_i sampled on the last cycle only.
REQ-022 On C_WAIT exit: N_i=1 -> F_ISSUE; N_i=0 and coarse count<MAX_COARSE -> C_ISSUE; N_i=0 and count=MAX_COARSE -> ERR.
REQ-023 F_ISSUE/F_WAIT SHALL mirror C_ISSUE/C_WAIT with mux_root_o=0 and the fine counter.
REQ-024 On F_WAIT exit: N_i=1 -> DONE; N_i=0 and fine count<MAX_FINE -> F_ISSUE; otherwise -> ERR.
REQ-025 Iteration period SHALL be 1+LAT cycles; with k total steps, DONE entry occurs exactly 2+k*(1+LAT) cycles after start_i is sampled.
REQ-026 DONE/ERR SHALL be held until ack_i=1.
REQ-027 ack_i=1 with start_i=0 -> IDLE; ack_i=1 with start_i=1 in the same cycle -> LOAD (back-to-back).
REQ-028 start_i SHALL be ignored while busy_o=1; ack_i SHALL be ignored outside DONE/ERR.
REQ-029 Coarse and fine counters SHALL clear on LOAD; counter width is clog2(MAX+1), and counters never wrap.
REQ-030 All outputs SHALL be registered-state decodes, glitch-free, with no combinational path from N_i to any output.

Reset
REQ-031 rst=1 SHALL force IDLE immediately, clear both counters, and drive every output to 0, including mid-operation.
REQ-032 After reset deassertion the first start_i SHALL be accepted on the next rising edge.

Configuration
REQ-033 With SQRT_CTRL_CYCLE_CNT_EN defined, the block SHALL add output cycles_o (8 bits): cycles from LOAD through the last WAIT cycle inclusive, saturating at 255, held through DONE/ERR, cleared on LOAD and reset.
REQ-034 Without SQRT_CTRL_CYCLE_CNT_EN, the cycles_o port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package sqrt_ctrl_pkg SHALL hold the state enum and the default LAT/MAX_COARSE/MAX_FINE constants.
REQ-036 Sub-module sqrt_step_counter (parameterised limit; clear, increment, at_limit) SHALL be instantiated once for coarse and once for fine.

Verification
REQ-037 Reset, then start_i pulse at cycle t with bench N_i=1 on both first steps -> wr_input_o at t+1, en_pipe_o at t+2 and t+6, done_o/ready_o at t+10, cycles_o=9.
REQ-038 N_i coarse sequence 0,0,1 then fine 0,1 -> k=5, DONE at t+22, mux_root_o=1 for the first 12 post-LOAD cycles then 0, cycles_o=21.
REQ-039 N_i held 0 -> 32 coarse en_pipe_o pulses, then ERR with err_o=1, done_o=1, ready_o=0; ack_i -> IDLE.
REQ-040 rst asserted during C_WAIT of the second step -> all outputs 0 within the same cycle, IDLE after release, and a new start completes normally.
REQ-041 In DONE drive ack_i=1 and start_i=1 together -> LOAD next cycle with wr_input_o=1; start_i pulses during busy cause no state change.
